// File: rtl/register_writeback.sv
// Register-file write front end: arbitrates ALU/load results into a small FIFO and drains one write per cycle.
// Optional WB_ZERO_REG_EN: results targeting index all-ones handshake normally but are dropped.
module register_writeback #(
  parameter int unsigned dataWidth    = 64,
  parameter int unsigned addressWidth = 5,
  parameter int unsigned fifoDepth    = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [addressWidth-1:0]    load_register,
  input  logic [dataWidth-1:0]       load_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [addressWidth-1:0]    alu_register,
  input  logic [dataWidth-1:0]       alu_data,
  output logic                       reg_write,
  output logic [addressWidth-1:0]    write_register,
  output logic [dataWidth-1:0]       write_data,
  output logic [$clog2(fifoDepth):0] pending_count,
  output logic                       busy
);

  localparam int unsigned PTR_W   = $clog2(fifoDepth);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = addressWidth + dataWidth;

  typedef enum logic {GRANT_LOAD = 1'b0, GRANT_ALU = 1'b1} grant_e;

  logic [ENTRY_W-1:0] mem [fifoDepth];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  grant_e             last_grant;
  grant_e             arb_grant;
  logic               arbitrated;
  logic [CNT_W-1:0]   free_slots;
  logic [CNT_W-1:0]   count_next;
  logic               load_is_zero;
  logic               alu_is_zero;
  logic               load_push;
  logic               alu_push;
  logic               pop;

`ifdef WB_ZERO_REG_EN
  assign load_is_zero = &load_register;
  assign alu_is_zero  = &alu_register;
`else
  assign load_is_zero = 1'b0;
  assign alu_is_zero  = 1'b0;
`endif

  assign free_slots = CNT_W'(fifoDepth) - pending_count;

  // Ready generation; on the last free slot with both offering, alternate the grant.
  always_comb begin
    load_ready = 1'b0;
    alu_ready  = 1'b0;
    arb_grant  = last_grant;
    arbitrated = 1'b0;
    if (free_slots >= CNT_W'(2)) begin
      load_ready = 1'b1;
      alu_ready  = 1'b1;
    end else if (free_slots == CNT_W'(1)) begin
      if (load_valid && alu_valid) begin
        arbitrated = 1'b1;
        if (last_grant == GRANT_ALU) begin
          load_ready = 1'b1;
          arb_grant  = GRANT_LOAD;
        end else begin
          alu_ready  = 1'b1;
          arb_grant  = GRANT_ALU;
        end
      end else begin
        load_ready = 1'b1;
        alu_ready  = 1'b1;
      end
    end
  end

  assign load_push  = load_valid && load_ready && !load_is_zero;
  assign alu_push   = alu_valid && alu_ready && !alu_is_zero;
  assign pop        = (pending_count != '0);
  assign count_next = pending_count + CNT_W'(load_push) + CNT_W'(alu_push) - CNT_W'(pop);

  // Load entry lands first so the ALU value for a shared index is written last.
  always_ff @(posedge clock) begin
    if (load_push) begin
      mem[wr_ptr] <= {load_register, load_data};
    end
    if (alu_push) begin
      mem[load_push ? wr_ptr + PTR_W'(1) : wr_ptr] <= {alu_register, alu_data};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pending_count  <= '0;
      last_grant     <= GRANT_ALU;
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      busy           <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr + PTR_W'(load_push) + PTR_W'(alu_push);
      rd_ptr        <= rd_ptr + PTR_W'(pop);
      pending_count <= count_next;
      reg_write     <= pop;
      busy          <= (count_next != '0) || pop;
      if (pop) begin
        {write_register, write_data} <= mem[rd_ptr];
      end
      if (arbitrated) begin
        last_grant <= arb_grant;
      end
    end
  end

endmodule

// File: tb/tb_register_writeback.sv
// Bench for register_writeback (fifoDepth 4): per-cycle vector table plus write scoreboard.
module tb_register_writeback;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [AW-1:0] load_register = '0;
  logic [DW-1:0] load_data = '0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [AW-1:0] alu_register = '0;
  logic [DW-1:0] alu_data = '0;
  logic          reg_write;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data;
  logic [CW-1:0] pending_count;
  logic          busy;

  register_writeback #(.dataWidth(DW), .addressWidth(AW), .fifoDepth(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_register(load_register), .load_data(load_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_register(alu_register), .alu_data(alu_data),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .pending_count(pending_count), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          lv;
    logic [AW-1:0] lr;
    logic [DW-1:0] ld;
    logic          av;
    logic [AW-1:0] ar;
    logic [DW-1:0] ad;
    logic          erl;
    logic          era;
    logic [CW-1:0] ecnt;
  } vec_t;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } wr_t;

  vec_t          vecs[$];
  wr_t           sb[$];
  int            n_tests = 0;
  int            n_fail = 0;
  logic [CW-1:0] prev_cnt = '0;

  function automatic vec_t mk(input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld,
                              input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                              input logic erl, input logic era, input logic [CW-1:0] ecnt);
    vec_t v;
    v.lv = lv; v.lr = lr; v.ld = ld; v.av = av; v.ar = ar; v.ad = ad;
    v.erl = erl; v.era = era; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic vec_t idle(input logic [CW-1:0] ecnt);
    return mk(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, ecnt);
  endfunction

  function automatic logic dropped(input logic [AW-1:0] r);
`ifdef WB_ZERO_REG_EN
    return &r;
`else
    return (r != r);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check mid-cycle, record accepted results for the scoreboard.
  task automatic step(input vec_t v);
    logic exp_rw;
    wr_t  w;
    load_valid = v.lv; load_register = v.lr; load_data = v.ld;
    alu_valid  = v.av; alu_register  = v.ar; alu_data  = v.ad;
    @(negedge clock);
    exp_rw = (prev_cnt != '0);
    if (v.lv) check("load_ready", 64'(load_ready), 64'(v.erl));
    if (v.av) check("alu_ready", 64'(alu_ready), 64'(v.era));
    check("pending_count", 64'(pending_count), 64'(v.ecnt));
    check("reg_write", 64'(reg_write), 64'(exp_rw));
    check("busy", 64'(busy), 64'((v.ecnt != '0) || exp_rw));
    if (reg_write) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL write_order: unexpected write reg %0d data %0h, expected none", write_register, write_data);
      end else begin
        w = sb.pop_front();
        check("write_register", 64'(write_register), 64'(w.idx));
        check("write_data", write_data, w.data);
      end
    end
    if (v.lv && v.erl && !dropped(v.lr)) begin
      w.idx = v.lr; w.data = v.ld; sb.push_back(w);
    end
    if (v.av && v.era && !dropped(v.ar)) begin
      w.idx = v.ar; w.data = v.ad; sb.push_back(w);
    end
    prev_cnt = v.ecnt;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // single ALU result into an empty FIFO
    vecs.push_back(mk(0, 0, 0, 1, 3, 64'h1234, 1, 1, 0));
    vecs.push_back(idle(1)); vecs.push_back(idle(0)); vecs.push_back(idle(0));
    // dual accept, distinct indices: load written first
    vecs.push_back(mk(1, 1, 64'hA, 1, 2, 64'hB, 1, 1, 0));
    vecs.push_back(idle(2)); vecs.push_back(idle(1)); vecs.push_back(idle(0)); vecs.push_back(idle(0));
    // dual accept, same index: ALU value written last
    vecs.push_back(mk(1, 5, 64'h1, 1, 5, 64'h2, 1, 1, 0));
    vecs.push_back(idle(2)); vecs.push_back(idle(1)); vecs.push_back(idle(0)); vecs.push_back(idle(0));
    // saturation: alternating grants on the last slot, single-port grants leave last_grant alone
    vecs.push_back(mk(1, 10, 64'h100, 1, 20, 64'h200, 1, 1, 0));
    vecs.push_back(mk(1, 11, 64'h101, 1, 21, 64'h201, 1, 1, 2));
    vecs.push_back(mk(1, 12, 64'h102, 1, 22, 64'h202, 1, 0, 3));
    vecs.push_back(mk(1, 13, 64'h103, 1, 22, 64'h202, 0, 1, 3));
    vecs.push_back(mk(1, 13, 64'h103, 1, 23, 64'h203, 1, 0, 3));
    vecs.push_back(mk(1, 14, 64'h104, 1, 23, 64'h203, 0, 1, 3));
    vecs.push_back(mk(1, 14, 64'h104, 0, 0, 0, 1, 1, 3));
    vecs.push_back(mk(0, 0, 0, 1, 24, 64'h204, 1, 1, 3));
    vecs.push_back(mk(1, 15, 64'h105, 1, 25, 64'h205, 1, 0, 3));
    vecs.push_back(mk(1, 16, 64'h106, 1, 25, 64'h205, 0, 1, 3));
    vecs.push_back(mk(1, 16, 64'h106, 0, 0, 0, 1, 1, 3));
    vecs.push_back(idle(3)); vecs.push_back(idle(2)); vecs.push_back(idle(1));
    vecs.push_back(idle(0)); vecs.push_back(idle(0));

    #2;
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_write_register", 64'(write_register), 64'd0);
    check("rst_write_data", write_data, 64'd0);
    check("rst_pending_count", 64'(pending_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i]) step(vecs[i]);

    // zero-register result
    step(mk(0, 0, 0, 1, 31, 64'h31, 1, 1, 0));
`ifdef WB_ZERO_REG_EN
    step(idle(0)); step(idle(0));
`else
    step(idle(1)); step(idle(0)); step(idle(0));
`endif

    // asynchronous reset with entries pending discards everything
    step(mk(1, 7, 64'h70, 1, 8, 64'h80, 1, 1, 0));
    step(mk(1, 9, 64'h90, 1, 12, 64'hC0, 1, 1, 2));
    check("pre_rst_count", 64'(pending_count), 64'd3);
    check("pre_rst_reg_write", 64'(reg_write), 64'd1);
    load_valid = 1'b0;
    alu_valid  = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_reg_write", 64'(reg_write), 64'd0);
    check("mid_rst_pending_count", 64'(pending_count), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_write_data", write_data, 64'd0);
    sb.delete();
    prev_cnt = '0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k < 6; k++) step(idle(0));

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
